// File: rtl/fetch_pkg.sv
// Shared types and helpers for the IF-stage halfword realignment queue.
package fetch_pkg;

    typedef logic [15:0] halfword_t;

    localparam int FETCH_DEPTH = 4;
    localparam int CAP         = 2 * FETCH_DEPTH;

    // Any encoding whose two low bits are not 2'b11 is a 16-bit compressed instruction.
    function automatic logic is_rvc(input halfword_t h);
        return h[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/fetch_align_buffer_chk.sv
// Invariant checker for the realignment queue: no overflow, no over-pop, word-aligned fetch.
module fetch_align_buffer_chk #(
    parameter int CAP_HW = 8
) (
    input logic                      clk,
    input logic                      reset,
    input logic [1:0]                push_n,
    input logic [1:0]                pop_n,
    input logic [$clog2(CAP_HW):0]   count,
    input logic [1:0]                imem_addr_lo
);

    localparam int CNT_W = $clog2(CAP_HW) + 1;

    // Evaluated every cycle outside reset.
    always @(posedge clk) begin
        if (!reset) begin
            a_no_overflow: assert (push_n == 2'd0 || count <= CNT_W'(CAP_HW - 2))
                else $error("push into queue holding %0d halfwords", count);
            a_no_overpop: assert (CNT_W'(pop_n) <= count)
                else $error("pop of %0d with only %0d queued", pop_n, count);
            a_addr_aligned: assert (imem_addr_lo == 2'b00)
                else $error("fetch address not word aligned");
        end
    end

endmodule

// File: rtl/fetch_align_buffer_hw_queue.sv
// Circular halfword FIFO: accepts 0/1/2 halfwords and releases 0/1/2 halfwords per cycle.
module hw_queue
    import fetch_pkg::*;
#(
    parameter int CAP_HW = CAP
) (
    input  logic                      clk,
    input  logic                      flush,
    input  logic [1:0]                push_n,
    input  halfword_t                 push_hw0,
    input  halfword_t                 push_hw1,
    input  logic [1:0]                pop_n,
    output halfword_t                 h0,
    output halfword_t                 h1,
    output logic [$clog2(CAP_HW):0]   count
);

    localparam int PTR_W = $clog2(CAP_HW);
    localparam int CNT_W = PTR_W + 1;

    halfword_t          mem_r [CAP_HW];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;

    // Pointers wrap naturally because CAP_HW is a power of two.
    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(push_n);
            rd_ptr_r <= rd_ptr_r + PTR_W'(pop_n);
            count_r  <= count_r + CNT_W'(push_n) - CNT_W'(pop_n);
        end
    end

    // Halfword storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (!flush && push_n != 2'd0) begin
            mem_r[wr_ptr_r] <= push_hw0;
        end
        if (!flush && push_n == 2'd2) begin
            mem_r[wr_ptr_r + PTR_W'(1)] <= push_hw1;
        end
    end

    assign h0    = mem_r[rd_ptr_r];
    assign h1    = mem_r[rd_ptr_r + PTR_W'(1)];
    assign count = count_r;

endmodule

// File: rtl/fetch_align_buffer.sv
// IF-stage realignment buffer: fetches aligned words and presents whole 16/32-bit
// instructions with their PC, so ID never stitches halves across fetch words.
module fetch_align_buffer
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = FETCH_DEPTH,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        is_compressed
);

    localparam int CAP_HW = 2 * DEPTH;
    localparam int CNT_W  = $clog2(CAP_HW) + 1;

    logic [31:0]      fetch_pc_r;
    logic [31:0]      head_pc_r;
    logic             kill_r;
    logic             drop_lo_r;
    logic             inflight_r;

    logic             flush_s;
    logic             push_en_s;
    logic [1:0]       push_n_s;
    halfword_t        push_hw0_s;
    halfword_t        push_hw1_s;
    logic [1:0]       pop_n_s;
    halfword_t        h0_s;
    halfword_t        h1_s;
    logic [CNT_W-1:0] count_s;
    logic [CNT_W:0]   occupancy_s;
    logic             req_s;
    logic             rvc_s;
    logic             valid_s;
    logic             xfer_s;
    logic             unused_pc_bit_s;

    assign unused_pc_bit_s = redirect_pc[0];

    hw_queue #(
        .CAP_HW (CAP_HW)
    ) u_queue (
        .clk      (clk),
        .flush    (flush_s),
        .push_n   (push_n_s),
        .push_hw0 (push_hw0_s),
        .push_hw1 (push_hw1_s),
        .pop_n    (pop_n_s),
        .h0       (h0_s),
        .h1       (h1_s),
        .count    (count_s)
    );

    // Request throttling, push selection and head-instruction decode.
    always_comb begin
        flush_s     = reset | redirect;
        // An outstanding request reserves room for the two halfwords it will return.
        occupancy_s = {1'b0, count_s} + {{(CNT_W-1){1'b0}}, inflight_r, 1'b0};
        req_s       = !flush_s && (occupancy_s <= (CNT_W+1)'(CAP_HW - 2));
        push_en_s   = imem_rvalid & ~kill_r & ~flush_s;
        push_hw0_s  = imem_rdata[15:0];
        push_hw1_s  = imem_rdata[31:16];
        push_n_s    = 2'd0;
        if (push_en_s && drop_lo_r) begin
            push_n_s   = 2'd1;
            push_hw0_s = imem_rdata[31:16];
        end else if (push_en_s) begin
            push_n_s   = 2'd2;
        end else begin
            push_n_s   = 2'd0;
        end
        rvc_s   = is_rvc(h0_s);
        valid_s = !flush_s && (rvc_s ? (count_s >= CNT_W'(1)) : (count_s >= CNT_W'(2)));
        xfer_s  = valid_s & inst_ready;
        pop_n_s = xfer_s ? (rvc_s ? 2'd1 : 2'd2) : 2'd0;
    end

    // Fetch/head PC tracking and redirect bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_r <= RESET_PC;
            head_pc_r  <= RESET_PC;
            kill_r     <= 1'b0;
            drop_lo_r  <= 1'b0;
            inflight_r <= 1'b0;
        end else if (redirect) begin
            fetch_pc_r <= {redirect_pc[31:2], 2'b00};
            head_pc_r  <= {redirect_pc[31:1], 1'b0};
            drop_lo_r  <= redirect_pc[1];
            // A response landing in the redirect cycle is already discarded by the flush.
            kill_r     <= inflight_r & ~imem_rvalid;
            inflight_r <= 1'b0;
        end else begin
            if (req_s) begin
                fetch_pc_r <= fetch_pc_r + 32'd4;
            end
            if (xfer_s) begin
                head_pc_r <= head_pc_r + (rvc_s ? 32'd2 : 32'd4);
            end
            if (imem_rvalid) begin
                kill_r    <= 1'b0;
                drop_lo_r <= drop_lo_r & kill_r;
            end
            inflight_r <= req_s;
        end
    end

    assign imem_req      = req_s;
    assign imem_addr     = fetch_pc_r;
    assign inst_valid    = valid_s;
    assign inst_o        = rvc_s ? {16'h0000, h0_s} : {h1_s, h0_s};
    assign pc_o          = head_pc_r;
    assign is_compressed = rvc_s;

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Scoreboard bench: a program-level model of the instruction stream predicts every transfer.
module tb_fetch_align_buffer;
    import fetch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        is_compressed;

    always #5 clk = ~clk;

    fetch_align_buffer #(.DEPTH(FETCH_DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_o(inst_o), .pc_o(pc_o), .is_compressed(is_compressed)
    );

    fetch_align_buffer_chk #(.CAP_HW(CAP)) u_chk (
        .clk(clk), .reset(reset), .push_n(dut.push_n_s), .pop_n(dut.pop_n_s),
        .count(dut.count_s), .imem_addr_lo(imem_addr[1:0])
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        c;
    } exp_t;

    int          total = 0;
    int          bad   = 0;
    int          xfers = 0;
    logic [31:0] word_mem [logic [31:0]];
    exp_t        exp_q [$];
    logic [31:0] model_pc;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] get_word(input logic [31:0] a);
        logic [15:0] lo;
        logic [15:0] hi;
        if (!word_mem.exists(a)) begin
            lo = 16'($urandom);
            hi = 16'($urandom);
            if ($urandom_range(0, 1) == 1) lo[1:0] = 2'b11;
            if ($urandom_range(0, 1) == 1) hi[1:0] = 2'b11;
            word_mem[a] = {hi, lo};
        end
        return word_mem[a];
    endfunction

    function automatic logic [15:0] hw_at(input logic [31:0] p);
        logic [31:0] w;
        w = get_word({p[31:2], 2'b00});
        return p[1] ? w[31:16] : w[15:0];
    endfunction

    // Program semantics: decode the instruction starting at model_pc and step past it.
    task automatic push_expected();
        logic [15:0] a;
        exp_t        e;
        a    = hw_at(model_pc);
        e.pc = model_pc;
        if (a[1:0] != 2'b11) begin
            e.inst   = {16'h0000, a};
            e.c      = 1'b1;
            model_pc = model_pc + 32'd2;
        end else begin
            e.inst   = {hw_at(model_pc + 32'd2), a};
            e.c      = 1'b0;
            model_pc = model_pc + 32'd4;
        end
        exp_q.push_back(e);
    endtask

    task automatic top_up();
        while (exp_q.size() < 16) push_expected();
    endtask

    task automatic sb_restart(input logic [31:0] pc);
        exp_q.delete();
        model_pc = {pc[31:1], 1'b0};
        top_up();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        top_up();
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        tick();
        redirect    = 1'b1;
        redirect_pc = pc;
        sb_restart(pc);
        tick();
        redirect    = 1'b0;
    endtask

    // Memory: fixed one-cycle response to each request.
    initial begin
        logic        req_q;
        logic [31:0] addr_q;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            req_q  = imem_req;
            addr_q = imem_addr;
            @(posedge clk);
            #1;
            imem_rvalid = req_q;
            imem_rdata  = req_q ? get_word(addr_q) : 32'h0;
        end
    end

    // Monitor: every accepted instruction must be the next one the model predicted.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (inst_valid && inst_ready) begin
                xfers++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_underflow: got transfer at pc %0h, expected none", pc_o);
                end else begin
                    e = exp_q.pop_front();
                    check("xfer {pc,inst,c}", 96'({pc_o, inst_o, is_compressed}), 96'(e));
                end
            end
        end
    end

    initial begin
        int          r;
        logic [31:0] pc;
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        inst_ready  = 1'b1;
        for (int i = 0; i < 16; i++) word_mem[32'(i * 4)] = 32'h0000_0013;
        word_mem[32'h200] = 32'h4501_4505;
        word_mem[32'h300] = 32'h0513_4505;
        word_mem[32'h304] = 32'h0000_0000;

        // Reset state and first-instruction latency.
        repeat (3) tick();
        @(negedge clk);
        check("rst_req", 96'(imem_req), 96'(1'b0));
        check("rst_valid", 96'(inst_valid), 96'(1'b0));
        tick();
        reset = 1'b0;
        sb_restart(RESET_PC);
        @(negedge clk);
        check("c0_req_addr", 96'({imem_req, imem_addr}), 96'({1'b1, RESET_PC}));
        check("c0_valid", 96'(inst_valid), 96'(1'b0));
        tick();
        @(negedge clk);
        check("c1_valid", 96'(inst_valid), 96'(1'b0));
        tick();
        @(negedge clk);
        check("c2_valid_pc", 96'({inst_valid, pc_o}), 96'({1'b1, 32'h0}));
        repeat (5) tick();

        // Two compressed instructions in one word, then RVC followed by 32-bit.
        redirect_to(32'h200);
        repeat (6) tick();
        redirect_to(32'h300);
        repeat (6) tick();

        // Start on the upper half: lower half dropped, 32-bit inst held until next word.
        redirect_to(32'h302);
        @(negedge clk);
        check("split_req_addr", 96'({imem_req, imem_addr}), 96'({1'b1, 32'h300}));
        tick();
        @(negedge clk);
        check("split_r2_valid", 96'(inst_valid), 96'(1'b0));
        tick();
        @(negedge clk);
        check("split_hold", 96'(inst_valid), 96'(1'b0));
        tick();
        @(negedge clk);
        check("split_release", 96'({inst_valid, pc_o, inst_o}), 96'({1'b1, 32'h302, 32'h0000_0513}));
        repeat (4) tick();

        // Redirect with a response in flight.
        redirect_to(32'h100);
        repeat (4) tick();
        redirect_to(32'h102);
        @(negedge clk);
        check("redir_req_addr", 96'({imem_req, imem_addr}), 96'({1'b1, 32'h100}));
        repeat (6) tick();

        // Backpressure until full.
        tick();
        inst_ready = 1'b0;
        repeat (20) tick();
        @(negedge clk);
        check("full_req", 96'(imem_req), 96'(1'b0));
        check("full_valid", 96'(inst_valid), 96'(1'b1));
        tick();
        inst_ready = 1'b1;
        repeat (12) tick();

        // Reset mid-stream.
        tick();
        reset = 1'b1;
        sb_restart(RESET_PC);
        @(negedge clk);
        check("midrst_req_valid", 96'({imem_req, inst_valid}), 96'(2'b00));
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("restart", 96'({inst_valid, imem_req, imem_addr}), 96'({1'b0, 1'b1, RESET_PC}));
        repeat (6) tick();

        // Address wrap past 2^32.
        redirect_to(32'hFFFF_FFFA);
        @(negedge clk);
        check("wrap_addr", 96'(imem_addr), 96'(32'hFFFF_FFF8));
        repeat (12) tick();

        // Randomized traffic: stalls, redirects (odd bit 0 ignored), occasional reset.
        for (int n = 0; n < 800; n++) begin
            tick();
            redirect   = 1'b0;
            reset      = 1'b0;
            inst_ready = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 99);
            if (r < 4) begin
                if (r == 0) pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                else        pc = 32'h1000 + 32'($urandom_range(0, 1023));
                redirect    = 1'b1;
                redirect_pc = pc;
                sb_restart(pc);
            end else if (r == 4) begin
                reset = 1'b1;
                sb_restart(RESET_PC);
            end
        end
        tick();
        redirect   = 1'b0;
        reset      = 1'b0;
        inst_ready = 1'b1;
        repeat (6) tick();
        check("progress", 96'(xfers > 200), 96'(1'b1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
